// File: rtl/serdes.sv
// Loopback SERDES: a word is framed as start / data (LSB first) / even parity / stop on an
// internal registered serial line, then deserialized and parity-checked on the same clock.
module serdes #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              Cin,
  input  logic [DATA_W-1:0] Din,
  output logic [DATA_W-1:0] Dout,
  output logic              Done
);

  localparam int               CNT_W    = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  // TX state names what the line will carry after the next edge.
  typedef enum logic [1:0] {TX_IDLE, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PARITY} rx_state_t;

  tx_state_t         r_tx_state;
  logic [DATA_W-1:0] r_tx_shift;
  logic              r_tx_par;
  logic [CNT_W-1:0]  r_tx_cnt;
  logic              r_line;

  rx_state_t         r_rx_state;
  logic [DATA_W-1:0] r_rx_shift;
  logic [CNT_W-1:0]  r_rx_cnt;
  logic [DATA_W-1:0] r_dout;
  logic              r_done;

  function automatic logic even_parity(input logic [DATA_W-1:0] w);
    return ^w;
  endfunction

  // Serializer: rst_n is active-high despite its name.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_tx_state <= TX_IDLE;
      r_tx_shift <= '0;
      r_tx_par   <= 1'b0;
      r_tx_cnt   <= '0;
      r_line     <= 1'b0;
    end else begin
      case (r_tx_state)
        TX_IDLE: begin
          if (Cin) begin
            r_tx_shift <= Din;
            r_tx_par   <= even_parity(Din);
            r_tx_cnt   <= '0;
            r_line     <= 1'b1;
            r_tx_state <= TX_DATA;
          end else begin
            r_line <= 1'b0;
          end
        end
        TX_DATA: begin
          r_line     <= r_tx_shift[0];
          r_tx_shift <= {1'b0, r_tx_shift[DATA_W-1:1]};
          r_tx_cnt   <= r_tx_cnt + 1'b1;
          if (r_tx_cnt == LAST_BIT) r_tx_state <= TX_PARITY;
        end
        TX_PARITY: begin
          r_line     <= r_tx_par;
          r_tx_state <= TX_STOP;
        end
        TX_STOP: begin
          r_line     <= 1'b0;
          r_tx_state <= TX_IDLE;
        end
        default: begin
          r_line     <= 1'b0;
          r_tx_state <= TX_IDLE;
        end
      endcase
    end
  end

  // Deserializer: start bit seen one edge after acceptance, data then parity follow.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_rx_state <= RX_IDLE;
      r_rx_shift <= '0;
      r_rx_cnt   <= '0;
      r_dout     <= '0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_rx_state)
        RX_IDLE: begin
          if (r_line) begin
            r_rx_cnt   <= '0;
            r_rx_state <= RX_DATA;
          end
        end
        RX_DATA: begin
          r_rx_shift <= {r_line, r_rx_shift[DATA_W-1:1]};
          r_rx_cnt   <= r_rx_cnt + 1'b1;
          if (r_rx_cnt == LAST_BIT) r_rx_state <= RX_PARITY;
        end
        RX_PARITY: begin
          if (r_line == even_parity(r_rx_shift)) begin
            r_dout <= r_rx_shift;
            r_done <= 1'b1;
          end
          r_rx_state <= RX_IDLE;
        end
        default: r_rx_state <= RX_IDLE;
      endcase
    end
  end

  assign Dout = r_dout;
  assign Done = r_done;

endmodule

// File: tb/tb_serdes.sv
// Scoreboard bench for serdes: a frame-level model predicts the serial line, Done timing and Dout.
module tb_serdes;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic        Cin   = 1'b0;
  logic [31:0] Din   = '0;
  logic [31:0] Dout;
  logic        Done;

  serdes dut (.clk(clk), .rst_n(rst_n), .Cin(Cin), .Din(Din), .Dout(Dout), .Done(Done));

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] w;
    int          due;
  } exp_t;

  exp_t        sb[$];
  int          cyc = 0;
  int          n_chk = 0;
  int          n_fail = 0;
  logic        corrupt_next = 1'b0;
  logic        skip_line = 1'b0;
  logic        act_valid = 1'b0;
  logic [31:0] act_w = '0;
  int          act_k = 0;
  int          free_at = 0;
  logic [31:0] exp_dout = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // Expected line after edge e: start at acceptance edge, then data LSB first, parity, stop.
  function automatic logic exp_line(input int e);
    int d;
    if (!act_valid) return 1'b0;
    d = e - act_k;
    if (d == 0) return 1'b1;
    if (d >= 1 && d <= 32) return act_w[d-1];
    if (d == 33) return ^act_w;
    return 1'b0;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Frame model: a frame occupies 35 edges; Cin is accepted only once the previous one ended.
  always @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      act_valid <= 1'b0;
      free_at   <= 0;
      sb.delete();
    end else if (Cin && (cyc + 1) >= free_at) begin
      act_valid <= 1'b1;
      act_w     <= Din;
      act_k     <= cyc + 1;
      free_at   <= cyc + 36;
      if (!corrupt_next) sb.push_back('{Din, cyc + 35});
    end
  end

  initial begin : monitor
    logic exp_done;
    forever begin
      @(negedge clk);
      if (rst_n) exp_dout = '0;
      exp_done = (sb.size() > 0) && (sb[0].due == cyc);
      chk("done", 32'(Done), 32'(exp_done));
      if (exp_done) begin
        exp_dout = sb[0].w;
        void'(sb.pop_front());
      end
      chk("dout", Dout, exp_dout);
      if (!skip_line) chk("line", 32'(dut.r_line), 32'(exp_line(cyc)));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) tick();
  endtask

  task automatic send(input logic [31:0] w);
    Din = w;
    Cin = 1'b1;
    tick();
    Cin = 1'b0;
    Din = $urandom;
  endtask

  initial begin : stimulus
    logic b;
    wait_cycles(3);
    chk("rst_dout", Dout, 32'h0);
    chk("rst_done", 32'(Done), 32'h0);
    chk("rst_line", 32'(dut.r_line), 32'h0);

    // Cin while reset is held must not start anything
    Cin = 1'b1;
    Din = 32'h5555AAAA;
    wait_cycles(2);
    Cin = 1'b0;
    rst_n = 1'b0;
    wait_cycles(3);

    send(32'hDEADBEEF);
    wait_cycles(40);

    send(32'h00000000);
    wait_cycles(40);
    send(32'hFFFFFFFF);
    wait_cycles(40);

    // Cin held high: three back-to-back frames, Din changed right after each acceptance
    Din = 32'h12345678;
    Cin = 1'b1;
    tick();
    Din = 32'h9ABCDEF0;
    wait_cycles(35);
    Din = 32'h0F0F0F0F;
    wait_cycles(35);
    Cin = 1'b0;
    Din = $urandom;
    wait_cycles(40);

    // second strobe 10 cycles into a frame
    send(32'hA5A50001);
    wait_cycles(9);
    send(32'h11112222);
    wait_cycles(40);

    // reset mid-frame
    send(32'hCAFEBABE);
    wait_cycles(19);
    rst_n = 1'b1;
    tick();
    chk("abort_dout", Dout, 32'h0);
    chk("abort_done", 32'(Done), 32'h0);
    rst_n = 1'b0;
    wait_cycles(2);
    send(32'h600DF00D);
    wait_cycles(40);

    // single flipped data bit on the line
    corrupt_next = 1'b1;
    send($urandom);
    corrupt_next = 1'b0;
    wait_cycles(5);
    b = dut.r_line;
    skip_line = 1'b1;
    force dut.r_line = ~b;
    #7;
    release dut.r_line;
    skip_line = 1'b0;
    wait_cycles(40);

    for (int i = 0; i < 10; i++) begin
      send($urandom);
      wait_cycles($urandom_range(30, 42));
    end
    wait_cycles(40);

    chk("sb_empty", 32'(sb.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/serdes.md
SERDES -- requirements
Module: serdes

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; the reset port is named rst_n as in the codebase and is asserted when 1 despite its suffix.
REQ-002 Port list:
- clk   input   1    rising-edge clock for all state.
- rst_n input   1    asynchronous reset, active-high.
- Cin   input   1    start strobe, sampled on rising clk.
- Din   input   32   parallel word to transmit.
- Dout  output  32   last correctly received word.
- Done  output  1    one-cycle pulse, Dout updated.

Function
REQ-003 The block SHALL be a serializer (TX) driving an internal 1-bit registered serial line that loops back into a deserializer (RX), with no external serial pins.
REQ-004 TX states:
- IDLE: line = 0.
- START: line = 1.
- DATA: 32 cycles, Din bits LSB first.
- PARITY: line = even parity, i.e. XOR of the 32 bits.
- STOP: line = 0, 1 cycle, then back to IDLE.
REQ-005 In TX IDLE, Cin = 1 at rising edge k SHALL capture Din into the TX shift register, and the line SHALL be 1 (start) after edge k.
- Din is don't-care after edge k.
REQ-006 The line SHALL carry data bit i after edge k+1+i (i = 0..31), parity after edge k+33, and stop (0) after edge k+34.
- TX SHALL be in IDLE after edge k+35.
REQ-007 Cin SHALL be ignored in every TX state except IDLE; the earliest next accepted Cin is at edge k+35.
REQ-008 RX states:
- IDLE: waits for line = 1, detected at edge k+1.
- DATA: samples bits 0..31 at edges k+2..k+33 into a 32-bit shift register, LSB first.
- PARITY: samples parity at edge k+34, then returns to IDLE.
REQ-009 At edge k+34, if the received parity equals the XOR of the received data:
- Dout SHALL load the received word.
- Done SHALL be 1 for exactly the one cycle following edge k+34, i.e. latency 34 cycles from Cin sampling to Done.
REQ-010 On parity mismatch, Done SHALL stay 0 and Dout SHALL keep its previous value.
REQ-011 Dout SHALL hold its value between frames; Done SHALL be 0 at all times other than REQ-009.
REQ-012 Cin held high continuously SHALL start back-to-back frames every 35 cycles, with every frame received correctly.
REQ-013 All state, Dout and Done SHALL be registered; there SHALL be no combinational path from Cin or Din to outputs.

Reset
REQ-014 While rst_n = 1, asynchronously:
- TX and RX SHALL be in IDLE.
- The serial line SHALL be 0.
- Both shift registers SHALL be 0.
- Dout SHALL be 32'h0 and Done SHALL be 0.
REQ-015 Reset asserted mid-frame SHALL abort the frame, with no Done and Dout = 0.
- After release, the first Cin SHALL start a clean frame.
REQ-016 Cin SHALL be ignored while reset is asserted.

Verification
REQ-017 Bench SHALL cover these directed scenarios:
- Reset, then Din = 32'hDEADBEEF with a 1-cycle Cin -> Done pulses exactly 34 cycles later with Dout = 32'hDEADBEEF, and Done = 0 otherwise.
- Din = 32'h00000000, then 32'hFFFFFFFF, as separate frames -> Dout matches each word; line shows parity 0 for both words.
- Cin held high for 3 frames, Din = 32'h12345678 / 32'h9ABCDEF0 / 32'h0F0F0F0F changed right after each acceptance -> 3 Done pulses 35 cycles apart with matching Dout values.
- Second Cin pulse 10 cycles into a frame -> ignored; exactly one Done pulse.
- Reset asserted 20 cycles into a 32'hCAFEBABE frame -> no Done, Dout = 0; the next frame after release delivers its word correctly.
- Forced line bit flip in DATA (bench force on internal line) -> no Done, Dout unchanged.
